// File: rtl/rng_sched_pkg.sv
// rng_sched_pkg: shared scheduler state type and tag-width helper
package rng_sched_pkg;
  typedef enum logic {IDLE, BUSY} sched_state_t;
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rng_sched_rr.sv
// rng_sched_rr: combinational round-robin picker, nearest requester after ptr wins
module rng_sched_rr
  import rng_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = id_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] pick_o,
  output logic         any_o
);
  // distance 0 is ptr+1, distance N-1 is ptr itself (lowest priority)
  always_comb begin
    int best, d;
    best = N;
    d = 0;
    pick_o = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - 1 - int'(ptr_i)) % N;
      if (req_i[i] && d < best) begin
        best = d;
        pick_o = W'(i);
      end
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/rng_sched.sv
// rng_sched: round-robin sharing of one rng between requesters; RNG_SCHED_CHECK_EN adds sim assertions
module rng_sched
  import rng_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W_CFG = 48,
  parameter int W_DOUT = 17,
  localparam int W_ID = id_width(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*W_CFG-1:0]   req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic                     cfg_valid_o,
  input  logic                     cfg_ready_i,
  output logic [W_CFG-1:0]         cfg_data_o,
  input  logic                     rng_dout_valid_i,
  output logic                     rng_dout_ready_o,
  input  logic [W_DOUT-1:0]        rng_dout_data_i,
  output logic                     dout_valid_o,
  input  logic                     dout_ready_i,
  output logic [W_ID+W_DOUT-1:0]   dout_data_o
);
  sched_state_t state_q, state_d;
  logic [W_CFG-1:0] cfg_q, cfg_pick;
  logic [W_ID-1:0] grant_q, ptr_q, pick;
  logic any_req, done, capture, busy;
  rng_sched_rr #(.N(N_REQ), .W(W_ID)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .pick_o(pick),
    .any_o (any_req)
  );
  assign busy = state_q == BUSY;
  assign done = cfg_valid_o & cfg_ready_i;
  assign capture = any_req & (~busy | done);
  assign req_ready_o = capture ? N_REQ'(1) << pick : '0;
  assign state_d = capture ? BUSY : done ? IDLE : state_q;
  // select the winning requester's cfg word
  always_comb begin
    cfg_pick = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick == W_ID'(i)) cfg_pick = req_data_i[i*W_CFG +: W_CFG];
  end
  // scheduler state: capture loads cfg, grant and pointer; eot without a waiter returns to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q <= '0;
      grant_q <= '0;
      ptr_q <= W_ID'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      if (capture) begin
        cfg_q <= cfg_pick;
        grant_q <= pick;
        ptr_q <= pick;
      end
    end
  end
  assign cfg_valid_o = busy;
  assign cfg_data_o = cfg_q;
  assign dout_valid_o = rng_dout_valid_i & busy;
  assign dout_data_o = {grant_q, rng_dout_data_i};
  assign rng_dout_ready_o = dout_ready_i & busy;
`ifdef RNG_SCHED_CHECK_EN
  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready_o));
  a_cfg_stable: assert property (@(posedge clk) disable iff (rst)
    cfg_valid_o && !cfg_ready_i |=> $stable(cfg_data_o));
  a_idle_quiet: assert property (@(posedge clk) disable iff (rst) !busy |-> !rng_dout_valid_i);
  a_cfg_width: assert property (@(posedge clk) disable iff (rst) $bits(cfg_data_o) == W_CFG);
  for (genvar g = 0; g < N_REQ; g++) begin : g_hold
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      req_valid_i[g] && !req_ready_o[g] |=> req_valid_i[g]);
  end
`else
`endif
endmodule

// File: tb/tb_rng_sched.sv
// tb_rng_sched: directed scoreboard bench for rng_sched with a behavioural rng and requester queues
module tb_rng_sched;
  localparam int N = 3;
  localparam int WC = 48;
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*WC-1:0] req_data = '0;
  logic cfg_valid, cfg_ready;
  logic [WC-1:0] cfg_data;
  logic rng_valid, rng_ready;
  logic [16:0] rng_data;
  logic dout_valid;
  logic dout_ready = 1;
  logic [18:0] dout_data;
  always #5 clk = ~clk;
  rng_sched #(.N_REQ(N), .W_CFG(WC), .W_DOUT(17)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .cfg_valid_o(cfg_valid), .cfg_ready_i(cfg_ready), .cfg_data_o(cfg_data),
    .rng_dout_valid_i(rng_valid), .rng_dout_ready_o(rng_ready), .rng_dout_data_i(rng_data),
    .dout_valid_o(dout_valid), .dout_ready_i(dout_ready), .dout_data_o(dout_data)
  );
  // behavioural rng: cfg = {incr, cnt, base}, emits base + k*incr, eot on the last item
  logic [15:0] idx_q;
  logic eot;
  assign eot = idx_q == cfg_data[31:16] - 16'd1;
  assign rng_valid = cfg_valid;
  assign rng_data = {eot, 16'(cfg_data[15:0] + idx_q * cfg_data[47:32])};
  assign cfg_ready = cfg_valid & rng_ready & eot;
  always_ff @(posedge clk or posedge rst)
    if (rst) idx_q <= '0;
    else if (rng_valid && rng_ready) idx_q <= eot ? '0 : idx_q + 16'd1;
  int passed = 0, failed = 0, total = 0;
  int acks [N];
  int run = 0, max_run = 0, n_pop = 0;
  logic [18:0] sb [$];
  logic [47:0] rq [N][$];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [47:0] cw(input int incr, input int cnt, input int base);
    return {16'(incr), 16'(cnt), 16'(base)};
  endfunction
  task automatic exp_seq(input int id, input int incr, input int cnt, input int base);
    for (int k = 0; k < cnt; k++) sb.push_back({2'(id), k == cnt - 1, 16'(base + k * incr)});
  endtask
  function automatic bit pending();
    return sb.size() != 0 || cfg_valid || rq[0].size() != 0 || rq[1].size() != 0 || rq[2].size() != 0;
  endfunction
  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (pending() && k < 300) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk({tag, "_sb_left"}, 64'(sb.size()), 0);
    chk({tag, "_cfg_valid"}, 64'(cfg_valid), 0);
  endtask
  initial begin
    int a0;
    logic [47:0] w;
    for (int i = 0; i < N; i++) acks[i] = 0;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (dout_valid && dout_ready) begin
            run++;
            if (run > max_run) max_run = run;
            n_pop++;
            if (sb.size() == 0) begin
              total++;
              failed++;
              $error("FAIL dout_extra: observed %0h expected none", dout_data);
            end else chk("dout", 64'(dout_data), 64'(sb.pop_front()));
          end else run = 0;
        end
      end
      begin : requesters
        logic [N-1:0] a;
        forever begin
          @(posedge clk);
          a = rst ? '0 : req_ready;
          #1;
          for (int i = 0; i < N; i++)
            if (a[i] && rq[i].size() != 0) begin
              void'(rq[i].pop_front());
              acks[i]++;
            end
          for (int i = 0; i < N; i++) begin
            req_valid[i] = rq[i].size() != 0;
            req_data[i*WC +: WC] = req_valid[i] ? rq[i][0] : '0;
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "timeout");
      end
    join_none
    #3;
    chk("rst_cfg_valid", 64'(cfg_valid), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    @(posedge clk);
    #2;
    chk("post_rst_cfg_valid", 64'(cfg_valid), 0);
    chk("post_rst_dout_valid", 64'(dout_valid), 0);
    chk("post_rst_req_ready", 64'(req_ready), 0);
    chk("post_rst_rng_ready", 64'(rng_ready), 0);
    rq[0].push_back(cw(1, 2, 0));
    rq[1].push_back(cw(1, 2, 20));
    rq[2].push_back(cw(1, 2, 40));
    exp_seq(0, 1, 2, 0);
    exp_seq(1, 1, 2, 20);
    exp_seq(2, 1, 2, 40);
    run = 0;
    max_run = 0;
    wait_idle("all3");
    chk("all3_no_bubble", 64'(max_run), 6);
    chk("all3_acks", 64'(acks[0] * 100 + acks[1] * 10 + acks[2]), 111);
    a0 = acks[1];
    w = cw(1, 4, 10);
    rq[1].push_back(w);
    exp_seq(1, 1, 4, 10);
    @(posedge clk);
    #2;
    chk("lat_req_ready", 64'(req_ready), 3'b010);
    chk("lat_cfg_not_yet", 64'(cfg_valid), 0);
    @(posedge clk);
    #2;
    chk("lat_cfg_valid", 64'(cfg_valid), 1);
    chk("lat_dout_valid", 64'(dout_valid), 1);
    chk("lat_cfg_data", 64'(cfg_data), 64'(w));
    wait_idle("single");
    chk("single_ack_once", 64'(acks[1] - a0), 1);
    rq[2].push_back(cw(2, 3, 5));
    exp_seq(2, 2, 3, 5);
    wait_idle("r2_alone");
    rq[0].push_back(cw(1, 2, 70));
    rq[2].push_back(cw(1, 2, 80));
    exp_seq(0, 1, 2, 70);
    exp_seq(2, 1, 2, 80);
    wait_idle("fair");
    a0 = acks[1];
    w = cw(3, 5, 100);
    rq[1].push_back(w);
    exp_seq(1, 3, 5, 100);
    for (int c = 0; c < 80 && pending(); c++) begin
      @(posedge clk);
      #2;
      dout_ready = (c % 4 == 0) || (c % 4 == 3);
      if (cfg_valid) begin
        chk("stall_cfg_stable", 64'(cfg_data), 64'(w));
        chk("stall_no_ack", 64'(req_ready), 0);
      end
    end
    dout_ready = 1;
    wait_idle("stall");
    chk("stall_ack_once", 64'(acks[1] - a0), 1);
    rq[0].push_back(cw(1, 8, 200));
    exp_seq(0, 1, 8, 200);
    n_pop = 0;
    for (int k = 0; k < 100 && n_pop < 2; k++) @(posedge clk);
    #2;
    chk("abort_third_item", 64'(dout_data), {2'd0, 1'b0, 16'd202});
    rst = 1;
    #1;
    chk("abort_cfg_valid", 64'(cfg_valid), 0);
    chk("abort_dout_valid", 64'(dout_valid), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    rq[1].push_back(cw(1, 2, 50));
    rq[0].push_back(cw(1, 2, 60));
    exp_seq(0, 1, 2, 60);
    exp_seq(1, 1, 2, 50);
    wait_idle("after_abort");
    a0 = acks[0];
    rq[0].push_back(cw(1, 2, 300));
    rq[0].push_back(cw(1, 3, 310));
    rq[0].push_back(cw(2, 1, 320));
    exp_seq(0, 1, 2, 300);
    exp_seq(0, 1, 3, 310);
    exp_seq(0, 2, 1, 320);
    run = 0;
    max_run = 0;
    wait_idle("regrant");
    chk("regrant_no_bubble", 64'(max_run), 6);
    chk("regrant_acks", 64'(acks[0] - a0), 3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
